router_rx_sink: RTL

- Hardware consumer for one output port of the 1x3 router.
- Watches vld_out_x, drives read_enb_x, and reassembles each packet: header {len[5:0], addr[1:0]}, len payload bytes, then one parity byte.
- Streams payload bytes downstream and checks even XOR parity over header plus payload.
- One instance per router output port (PORT_ID 0..2); also serves as the self-checking sink in system benches.

---
 rtl/router_pkg.sv | 17 +
 rtl/router_rx_timer.sv | 37 +++
 rtl/router_rx_sink.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: header field widths, rx FSM states and the
// default mid-packet stall limit.
package router_pkg;

    localparam int LEN_W       = 6;
    localparam int ADDR_W      = 2;
    localparam int DATA_W      = 8;
    localparam int TIMEOUT_DEF = 30;

    typedef enum logic [1:0] {
        IDLE,
        HDR_CAP,
        BODY,
        CHECK
    } rx_state_e;

endpackage

// File: rtl/router_rx_timer.sv
// Stall counter: counts enabled cycles since the last clear and pulses
// expire on the TIMEOUT-th one; holds its count when neither input is set.
module router_rx_timer #(
    parameter int TIMEOUT = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        expire = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CW'(TIMEOUT - 1)) begin
                expire = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/router_rx_sink.sv
// Router output-port consumer: reads header/payload/parity from the port FIFO,
// streams payload, checks parity/addr. Define ROUTER_RX_STATS_EN for counters.
module router_rx_sink
    import router_pkg::*;
#(
    parameter int PORT_ID = 0,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vld_out,
    input  logic [DATA_W-1:0] data_out,
    output logic              read_enb,
    input  logic              sink_ready,
    output logic              pl_valid,
    output logic [DATA_W-1:0] pl_data,
    output logic              pkt_done,
    output logic [LEN_W-1:0]  pkt_len,
    output logic              parity_err,
    output logic              addr_err,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  pkt_count,
    output logic [CNT_W-1:0]  err_count
);

    rx_state_e         state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] par_q, par_d;
    logic [DATA_W-1:0] pl_data_q, pl_data_d;
    logic              pl_valid_q, pl_valid_d;
    logic [LEN_W:0]    rd_rem_q, rd_rem_d;
    logic [LEN_W:0]    rx_rem_q, rx_rem_d;
    logic              inflight_q, inflight_d;
    logic              tmr_clr, tmr_en, tmr_expire;

    // Stall timer only advances while a body read is still owed and the FIFO is empty.
    assign tmr_en  = (state_q == BODY) & ~vld_out & (rd_rem_q != '0);
    assign tmr_clr = (state_q != BODY) | read_enb;

    router_rx_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (tmr_expire)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        addr_d     = addr_q;
        acc_d      = acc_q;
        par_d      = par_q;
        pl_data_d  = pl_data_q;
        pl_valid_d = 1'b0;
        rd_rem_d   = rd_rem_q;
        rx_rem_d   = rx_rem_q;
        inflight_d = 1'b0;
        read_enb   = 1'b0;
        case (state_q)
            IDLE: begin
                read_enb = vld_out;
                if (vld_out) state_d = HDR_CAP;
            end
            HDR_CAP: begin
                len_d    = data_out[DATA_W-1 -: LEN_W];
                addr_d   = data_out[ADDR_W-1:0];
                acc_d    = data_out;
                rd_rem_d = {1'b0, data_out[DATA_W-1 -: LEN_W]} + 1'b1;
                rx_rem_d = {1'b0, data_out[DATA_W-1 -: LEN_W]} + 1'b1;
                state_d  = BODY;
            end
            BODY: begin
                read_enb   = vld_out & (rd_rem_q != '0) & sink_ready;
                inflight_d = read_enb;
                if (read_enb) rd_rem_d = rd_rem_q - 1'b1;
                // The last byte counted by rx_rem is parity, never payload.
                if (inflight_q) begin
                    rx_rem_d = rx_rem_q - 1'b1;
                    if (rx_rem_q > (LEN_W+1)'(1)) begin
                        pl_valid_d = 1'b1;
                        pl_data_d  = data_out;
                        acc_d      = acc_q ^ data_out;
                    end else begin
                        par_d   = data_out;
                        state_d = CHECK;
                    end
                end
                if (tmr_expire) state_d = IDLE;
            end
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            addr_q     <= '0;
            acc_q      <= '0;
            par_q      <= '0;
            pl_data_q  <= '0;
            pl_valid_q <= 1'b0;
            rd_rem_q   <= '0;
            rx_rem_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            acc_q      <= acc_d;
            par_q      <= par_d;
            pl_data_q  <= pl_data_d;
            pl_valid_q <= pl_valid_d;
            rd_rem_q   <= rd_rem_d;
            rx_rem_q   <= rx_rem_d;
            inflight_q <= inflight_d;
        end
    end

    assign pl_valid    = pl_valid_q;
    assign pl_data     = pl_data_q;
    assign pkt_len     = len_q;
    assign pkt_done    = (state_q == CHECK);
    assign parity_err  = pkt_done & (acc_q != par_q);
    assign addr_err    = pkt_done & (addr_q != ADDR_W'(PORT_ID));
    assign timeout_err = tmr_expire;

`ifdef ROUTER_RX_STATS_EN
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        err_cnt_d = err_cnt_q;
        if (pkt_done) begin
            if (parity_err | addr_err) err_cnt_d = err_cnt_q + 1'b1;
            else                       pkt_cnt_d = pkt_cnt_q + 1'b1;
        end
        if (timeout_err) err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign pkt_count = pkt_cnt_q;
    assign err_count = err_cnt_q;
`else
    assign pkt_count = '0;
    assign err_count = '0;
`endif

endmodule
